low_freq_queue_ctrl: RTL and testbench

LOW_FREQ_QUEUE_CTRL -- requirements
Module: low_freq_queue_ctrl

---
 rtl/low_freq_queue_pkg.sv | 17 +
 rtl/low_freq_queue_ctrl_seq_cnt.sv | 31 +++
 rtl/low_freq_queue_ctrl.sv | 112 +++++++++++
 tb/tb_low_freq_queue_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/low_freq_queue_pkg.sv
// Shared types and defaults for the low-frequency sample queue controller.
// ptr_t is the buffer pointer type at the default depth.
package low_freq_queue_pkg;

   localparam int DEPTH_DEF   = 1024;
   localparam int SEQ_LEN_DEF = 1021;
   localparam int PTR_W       = $clog2(DEPTH_DEF);

   typedef logic [PTR_W-1:0] ptr_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      SEQ   = 2'd2
   } state_t;

endpackage

// File: rtl/low_freq_queue_ctrl_seq_cnt.sv
// Read-sequence length counter: loads SEQ_LEN-1, counts down while enabled,
// and flags the last cycle of a sequence with tc.
module seq_cnt
   import low_freq_queue_pkg::*;
#(
   parameter int SEQ_LEN = SEQ_LEN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam int CW = ($clog2(SEQ_LEN) > 0) ? $clog2(SEQ_LEN) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(SEQ_LEN - 1);
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/low_freq_queue_ctrl.sv
// Circular-buffer controller: writes each incoming sample, then once the buffer
// holds SEQ_LEN samples reads a SEQ_LEN-long window starting at the oldest one.
//
//   state | meaning
//   IDLE  | waiting for a sample strobe or a pending sample
//   WRITE | one-cycle buffer write at new_ptr
//   SEQ   | SEQ_LEN-cycle read of old_ptr .. old_ptr+SEQ_LEN-1
module low_freq_queue_ctrl
   import low_freq_queue_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEF,
   parameter int SEQ_LEN = SEQ_LEN_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     vld,
   output logic                     wrt_smpl,
   output logic [$clog2(DEPTH)-1:0] waddr,
   output logic [$clog2(DEPTH)-1:0] raddr,
   output logic                     sequencing,
   output logic                     is_full,
   output logic                     ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(SEQ_LEN + 1);

   state_t        state;
   logic [AW-1:0] new_ptr;
   logic [AW-1:0] old_ptr;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          pending;
   logic          seq_load;
   logic          seq_tc;

   assign cnt_inc  = (cnt == CW'(SEQ_LEN)) ? cnt : cnt + 1'b1;
   assign seq_load = (state == WRITE) && (cnt_inc == CW'(SEQ_LEN));
   assign waddr    = new_ptr;

   seq_cnt #(.SEQ_LEN(SEQ_LEN)) u_seq_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (seq_load),
      .en   (state == SEQ),
      .tc   (seq_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         new_ptr    <= '0;
         old_ptr    <= '0;
         cnt        <= '0;
         pending    <= 1'b0;
         ovf        <= 1'b0;
         wrt_smpl   <= 1'b0;
         sequencing <= 1'b0;
         is_full    <= 1'b0;
         raddr      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (vld || pending) begin
                  state    <= WRITE;
                  wrt_smpl <= 1'b1;
                  // a strobe arriving alongside a pending write becomes the next pending one
                  pending  <= vld & pending;
               end
            end
            WRITE: begin
               if (vld) begin
                  if (pending) ovf <= 1'b1;
                  else         pending <= 1'b1;
               end
               wrt_smpl <= 1'b0;
               new_ptr  <= new_ptr + 1'b1;
               cnt      <= cnt_inc;
               is_full  <= (cnt_inc == CW'(SEQ_LEN));
               if (seq_load) begin
                  state      <= SEQ;
                  sequencing <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            SEQ: begin
               if (vld) begin
                  if (pending) ovf <= 1'b1;
                  else         pending <= 1'b1;
               end
               if (seq_tc) begin
                  sequencing <= 1'b0;
                  old_ptr    <= old_ptr + 1'b1;
                  raddr      <= old_ptr + 1'b1;
                  if (pending) begin
                     state    <= WRITE;
                     wrt_smpl <= 1'b1;
                     pending  <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  raddr <= raddr + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_low_freq_queue_ctrl.sv
// Self-checking bench for low_freq_queue_ctrl against a write/sequence count model.
module tb_low_freq_queue_ctrl;
   import low_freq_queue_pkg::*;

   localparam int DEPTH   = DEPTH_DEF;
   localparam int SEQ_LEN = SEQ_LEN_DEF;
   localparam int AW      = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst;
   logic          vld;
   logic          wrt_smpl;
   logic          sequencing;
   logic          is_full;
   logic          ovf;
   logic [AW-1:0] waddr;
   logic [AW-1:0] raddr;

   int checks = 0;
   int errors = 0;

   // model: samples written, sequences completed, strobes seen since last write started
   int m_writes;
   int m_seqs;
   int m_pulses;
   bit m_ovf;
   bit m_follow;

   always #5 clk = ~clk;

   low_freq_queue_ctrl #(.DEPTH(DEPTH), .SEQ_LEN(SEQ_LEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .vld        (vld),
      .wrt_smpl   (wrt_smpl),
      .waddr      (waddr),
      .raddr      (raddr),
      .sequencing (sequencing),
      .is_full    (is_full),
      .ovf        (ovf)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time exceeded, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_writes = 0;
      m_seqs   = 0;
      m_pulses = 0;
      m_ovf    = 1'b0;
      m_follow = 1'b0;
   endtask

   // current cycle must be a write; optionally strobe vld during it
   task automatic do_write(input bit pulse_now);
      ptr_t exp_w;
      exp_w = ptr_t'(m_writes % DEPTH);
      checks++;
      if (wrt_smpl !== 1'b1 || sequencing !== 1'b0 || waddr !== exp_w) begin
         errors++;
         $display("FAIL write: wrt_smpl=%b sequencing=%b waddr=%0d, want 1 0 %0d",
                  wrt_smpl, sequencing, waddr, exp_w);
      end
      m_writes++;
      vld = pulse_now;
      if (pulse_now) m_pulses++;
      tick();
      vld = 1'b0;
      checks++;
      if (is_full !== (m_writes >= SEQ_LEN)) begin
         errors++;
         $display("FAIL is_full: got %b want %b after %0d writes", is_full, (m_writes >= SEQ_LEN), m_writes);
      end
   endtask

   // current cycle must be the first read cycle; strobe vld at read index k1/k2
   task automatic do_seq(input int k1, input int k2);
      int   bad_k;
      ptr_t exp_r;
      ptr_t bad_exp;
      logic [AW-1:0] bad_raddr;
      logic bad_s, bad_w;
      bad_k = -1;
      bad_exp = '0;
      bad_raddr = '0;
      bad_s = 1'b0;
      bad_w = 1'b0;
      for (int k = 0; k < SEQ_LEN; k++) begin
         exp_r = ptr_t'((m_seqs + k) % DEPTH);
         if (bad_k < 0 && (sequencing !== 1'b1 || wrt_smpl !== 1'b0 || raddr !== exp_r)) begin
            bad_k = k;
            bad_exp = exp_r;
            bad_raddr = raddr;
            bad_s = sequencing;
            bad_w = wrt_smpl;
         end
         vld = (k == k1) || (k == k2);
         if (vld) m_pulses++;
         tick();
      end
      vld = 1'b0;
      m_seqs++;
      checks++;
      if (bad_k >= 0) begin
         errors++;
         $display("FAIL seq: at k=%0d sequencing=%b wrt_smpl=%b raddr=%0d, want 1 0 %0d",
                  bad_k, bad_s, bad_w, bad_raddr, bad_exp);
      end
      checks++;
      if (sequencing !== 1'b0 || raddr !== ptr_t'(m_seqs % DEPTH)) begin
         errors++;
         $display("FAIL seq_end: sequencing=%b raddr=%0d, want 0 %0d",
                  sequencing, raddr, m_seqs % DEPTH);
      end
      if (m_pulses >= 2) m_ovf = 1'b1;
      checks++;
      if (ovf !== m_ovf) begin
         errors++;
         $display("FAIL ovf: got %b want %b", ovf, m_ovf);
      end
      m_follow = (m_pulses > 0);
      m_pulses = 0;
   endtask

   // n quiet cycles: no write, no read, addresses parked at the pointers
   task automatic idle_check(input int n);
      int bad_i;
      bad_i = -1;
      for (int i = 0; i < n; i++) begin
         if (bad_i < 0 && (wrt_smpl !== 1'b0 || sequencing !== 1'b0 ||
                           raddr !== ptr_t'(m_seqs % DEPTH) || waddr !== ptr_t'(m_writes % DEPTH)))
            bad_i = i;
         tick();
      end
      checks++;
      if (bad_i >= 0) begin
         errors++;
         $display("FAIL idle: cycle %0d wrt_smpl=%b sequencing=%b raddr=%0d waddr=%0d, want 0 0 %0d %0d",
                  bad_i, wrt_smpl, sequencing, raddr, waddr, m_seqs % DEPTH, m_writes % DEPTH);
      end
   endtask

   task automatic run_sample(input int gap);
      vld = 1'b1;
      tick();
      vld = 1'b0;
      do_write(1'b0);
      if (m_writes >= SEQ_LEN) do_seq(-1, -1);
      idle_check(gap);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      vld = 1'b1;
      repeat (3) tick();
      vld = 1'b0;
      checks++;
      if ({wrt_smpl, sequencing, is_full, ovf} !== 4'b0 || waddr !== '0 || raddr !== '0) begin
         errors++;
         $display("FAIL reset_outputs: wrt=%b seq=%b full=%b ovf=%b waddr=%0d raddr=%0d, want all 0",
                  wrt_smpl, sequencing, is_full, ovf, waddr, raddr);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({wrt_smpl, sequencing, is_full, ovf} !== 4'b0 || waddr !== '0 || raddr !== '0) begin
         errors++;
         $display("FAIL post_reset: wrt=%b seq=%b full=%b ovf=%b waddr=%0d raddr=%0d, want all 0",
                  wrt_smpl, sequencing, is_full, ovf, waddr, raddr);
      end
      model_reset();
   endtask

   task automatic test_fill();
      repeat (SEQ_LEN - 1) run_sample(6);
      checks++;
      if (is_full !== 1'b0 || waddr !== ptr_t'(SEQ_LEN - 1)) begin
         errors++;
         $display("FAIL fill: is_full=%b waddr=%0d, want 0 %0d", is_full, waddr, SEQ_LEN - 1);
      end
   endtask

   task automatic test_first_seq();
      run_sample(2);
      checks++;
      if (is_full !== 1'b1 || raddr !== ptr_t'(1)) begin
         errors++;
         $display("FAIL first_seq: is_full=%b raddr=%0d, want 1 1", is_full, raddr);
      end
   endtask

   task automatic test_wrap();
      repeat (4) run_sample(1);
      checks++;
      if (waddr !== ptr_t'(1) || raddr !== ptr_t'(5)) begin
         errors++;
         $display("FAIL wrap: waddr=%0d raddr=%0d, want 1 5", waddr, raddr);
      end
   endtask

   task automatic test_mid_seq_vld();
      vld = 1'b1;
      tick();
      vld = 1'b0;
      do_write(1'b0);
      do_seq(300, -1);
      do_write(1'b0);
      do_seq(-1, -1);
      idle_check(3);
   endtask

   task automatic test_overflow();
      vld = 1'b1;
      tick();
      vld = 1'b0;
      do_write(1'b0);
      do_seq(100, 700);
      do_write(1'b0);
      do_seq(-1, -1);
      idle_check(20);
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: got %b want 1", ovf);
      end
   endtask

   task automatic test_reset_mid_seq();
      vld = 1'b1;
      tick();
      vld = 1'b0;
      do_write(1'b0);
      repeat (500) tick();
      checks++;
      if (sequencing !== 1'b1 || raddr !== ptr_t'((m_seqs + 500) % DEPTH)) begin
         errors++;
         $display("FAIL pre_abort: sequencing=%b raddr=%0d, want 1 %0d",
                  sequencing, raddr, (m_seqs + 500) % DEPTH);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({wrt_smpl, sequencing, is_full, ovf} !== 4'b0 || waddr !== '0 || raddr !== '0) begin
         errors++;
         $display("FAIL abort: wrt=%b seq=%b full=%b ovf=%b waddr=%0d raddr=%0d, want all 0",
                  wrt_smpl, sequencing, is_full, ovf, waddr, raddr);
      end
      rst = 1'b0;
      model_reset();
      idle_check(2);
      repeat (SEQ_LEN) run_sample(1);
   endtask

   task automatic test_random();
      int nk, k1, k2;
      repeat (8) begin
         if (!m_follow) begin
            idle_check($urandom_range(0, 4));
            vld = 1'b1;
            tick();
            vld = 1'b0;
         end
         do_write($urandom_range(0, 3) == 0);
         nk = $urandom_range(0, 2);
         k1 = (nk >= 1) ? int'($urandom_range(0, 500)) : -1;
         k2 = (nk == 2) ? int'($urandom_range(501, SEQ_LEN - 2)) : -1;
         do_seq(k1, k2);
      end
      if (m_follow) begin
         do_write(1'b0);
         do_seq(-1, -1);
      end
      idle_check(5);
   endtask

   initial begin
      rst = 1'b1;
      vld = 1'b0;
      model_reset();
      test_reset();
      test_fill();
      test_first_seq();
      test_wrap();
      test_mid_seq_vld();
      test_overflow();
      test_reset_mid_seq();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
